// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one ideal_mem port pair between instruction fetch and data requesters.
// Optional MEM_ARB_WAIT_EN inserts WAIT_CYCLES wait cycles before each memory access.
module mem_arbiter #(
    parameter int ADDR_WIDTH  = 14,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  inst_req_valid,
    output logic                  inst_req_ready,
    input  logic [31:0]           inst_addr,
    output logic                  inst_resp_valid,
    input  logic                  inst_resp_ready,
    output logic [31:0]           inst_rdata,
    input  logic                  data_req_valid,
    output logic                  data_req_ready,
    input  logic [31:0]           data_addr,
    input  logic                  data_wen,
    input  logic [31:0]           data_wdata,
    input  logic [3:0]            data_wstrb,
    output logic                  data_resp_valid,
    input  logic                  data_resp_ready,
    output logic [31:0]           data_rdata,
    output logic [ADDR_WIDTH-3:0] mem_waddr,
    output logic [ADDR_WIDTH-3:0] mem_raddr,
    output logic                  mem_wren,
    output logic                  mem_rden,
    output logic [31:0]           mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic [31:0]           mem_rdata
);

`ifdef MEM_ARB_WAIT_EN
    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, RESP} state_t;
`else
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
`endif
    typedef enum logic {REQ_INST, REQ_DATA} req_t;

    state_t                state_q, state_d;
    req_t                  last_q, last_d;
    req_t                  owner_q, owner_d;
    logic [ADDR_WIDTH-3:0] addr_q, addr_d;
    logic                  wen_q, wen_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [3:0]            wstrb_q, wstrb_d;
    logic [31:0]           rdata_q, rdata_d;
`ifdef MEM_ARB_WAIT_EN
    logic [3:0]            cnt_q, cnt_d;
`endif

    logic grant_inst, grant_data;
    logic unused_ok;

`ifdef MEM_ARB_WAIT_EN
    assign unused_ok = ^{inst_addr[31:ADDR_WIDTH], inst_addr[1:0],
                         data_addr[31:ADDR_WIDTH], data_addr[1:0]};
`else
    assign unused_ok = ^{inst_addr[31:ADDR_WIDTH], inst_addr[1:0],
                         data_addr[31:ADDR_WIDTH], data_addr[1:0], WAIT_CYCLES != 0};
`endif

    // Ties go to the requester that was not served last.
    always_comb begin
        grant_inst = 1'b0;
        grant_data = 1'b0;
        if (state_q == IDLE && rst_n) begin
            if (inst_req_valid && (!data_req_valid || last_q == REQ_DATA))
                grant_inst = 1'b1;
            else if (data_req_valid)
                grant_data = 1'b1;
        end
    end

    always_comb begin
        state_d         = state_q;
        last_d          = last_q;
        owner_d         = owner_q;
        addr_d          = addr_q;
        wen_d           = wen_q;
        wdata_d         = wdata_q;
        wstrb_d         = wstrb_q;
        rdata_d         = rdata_q;
`ifdef MEM_ARB_WAIT_EN
        cnt_d           = cnt_q;
`endif
        mem_wren        = 1'b0;
        mem_rden        = 1'b0;
        inst_resp_valid = 1'b0;
        data_resp_valid = 1'b0;
        inst_rdata      = '0;
        data_rdata      = '0;

        case (state_q)
            IDLE: begin
                if (grant_inst || grant_data) begin
                    if (grant_inst) begin
                        owner_d = REQ_INST;
                        addr_d  = inst_addr[ADDR_WIDTH-1:2];
                        wen_d   = 1'b0;
                        wdata_d = '0;
                        wstrb_d = '0;
                    end else begin
                        owner_d = REQ_DATA;
                        addr_d  = data_addr[ADDR_WIDTH-1:2];
                        wen_d   = data_wen;
                        wdata_d = data_wdata;
                        wstrb_d = data_wstrb;
                    end
`ifdef MEM_ARB_WAIT_EN
                    cnt_d   = 4'(WAIT_CYCLES);
                    state_d = WAIT;
`else
                    state_d = ACCESS;
`endif
                end
            end
`ifdef MEM_ARB_WAIT_EN
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_d == 4'd0)
                    state_d = ACCESS;
            end
`endif
            ACCESS: begin
                // Enables gated by rst_n so a reset landing here never commits a write.
                mem_rden = !wen_q && rst_n;
                mem_wren = wen_q && rst_n;
                rdata_d  = wen_q ? '0 : mem_rdata;
                state_d  = RESP;
            end
            RESP: begin
                if (owner_q == REQ_INST) begin
                    inst_resp_valid = 1'b1;
                    inst_rdata      = rdata_q;
                end else begin
                    data_resp_valid = 1'b1;
                    data_rdata      = rdata_q;
                end
                if ((owner_q == REQ_INST && inst_resp_ready) ||
                    (owner_q == REQ_DATA && data_resp_ready)) begin
                    last_d  = owner_q;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            last_q  <= REQ_DATA;
            owner_q <= REQ_INST;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
`ifdef MEM_ARB_WAIT_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            owner_q <= owner_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
`ifdef MEM_ARB_WAIT_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

    assign inst_req_ready = grant_inst;
    assign data_req_ready = grant_data;
    assign mem_waddr      = addr_q;
    assign mem_raddr      = addr_q;
    assign mem_wdata      = wdata_q;
    assign mem_wstrb      = wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed table plus randomized transactions against a word-level model.
module tb_mem_arbiter;

    localparam int AW    = 14;
    localparam int WORDS = 4096;

    logic          clk;
    logic          rst_n;
    logic          inst_req_valid, inst_req_ready, inst_resp_valid, inst_resp_ready;
    logic [31:0]   inst_addr, inst_rdata;
    logic          data_req_valid, data_req_ready, data_wen, data_resp_valid, data_resp_ready;
    logic [31:0]   data_addr, data_wdata, data_rdata;
    logic [3:0]    data_wstrb;
    logic [AW-3:0] mem_waddr, mem_raddr;
    logic          mem_wren, mem_rden;
    logic [31:0]   mem_wdata, mem_rdata;
    logic [3:0]    mem_wstrb;

    mem_arbiter #(.ADDR_WIDTH(AW), .WAIT_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .inst_req_valid(inst_req_valid), .inst_req_ready(inst_req_ready), .inst_addr(inst_addr),
        .inst_resp_valid(inst_resp_valid), .inst_resp_ready(inst_resp_ready), .inst_rdata(inst_rdata),
        .data_req_valid(data_req_valid), .data_req_ready(data_req_ready), .data_addr(data_addr),
        .data_wen(data_wen), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_resp_valid(data_resp_valid), .data_resp_ready(data_resp_ready), .data_rdata(data_rdata),
        .mem_waddr(mem_waddr), .mem_raddr(mem_raddr), .mem_wren(mem_wren), .mem_rden(mem_rden),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] init_word(input int i);
        if (i == 4)  return 32'hDEAD_BEEF;
        if (i == 8)  return 32'hFFFF_FFFF;
        if (i == 12) return 32'hA5A5_A5A5;
        return 32'h5A5A_0000 ^ (i * 32'h0001_0203);
    endfunction

    // Ideal memory: combinational read, byte-strobed write on posedge.
    logic [31:0] mem [0:WORDS-1];
    bit          mem_init_q = 1'b0;
    assign mem_rdata = mem[mem_raddr];
    always @(posedge clk) begin
        if (!mem_init_q) begin
            for (int i = 0; i < WORDS; i++) mem[i] <= init_word(i);
            mem_init_q <= 1'b1;
        end else if (mem_wren) begin
            for (int b = 0; b < 4; b++)
                if (mem_wstrb[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: word array plus "who was served last".
    logic [31:0] ref_mem [0:WORDS-1];
    bit          m_last_data;

    task automatic model_step(input bit iv, input bit dv, input bit wen,
                              input logic [31:0] ia, input logic [31:0] da,
                              input logic [31:0] wd, input logic [3:0] ws,
                              output bit gi, output logic [31:0] rd);
        int w;
        gi = iv && (!dv || m_last_data);
        if (gi) begin
            w  = int'((ia % 32'h4000) / 4);
            rd = ref_mem[w];
            m_last_data = 1'b0;
        end else begin
            w = int'((da % 32'h4000) / 4);
            if (wen) begin
                for (int b = 0; b < 4; b++)
                    if (ws[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
                rd = '0;
            end else begin
                rd = ref_mem[w];
            end
            m_last_data = 1'b1;
        end
    endtask

    // Entered just after a posedge with the DUT idle; returns just after the posedge ending RESP.
    task automatic run_txn(input bit iv, input bit dv, input bit wen,
                           input logic [31:0] ia, input logic [31:0] da,
                           input logic [31:0] wd, input logic [3:0] ws,
                           input int stall, input bit gi, input logic [31:0] rd);
        logic [31:0] word;
        bit          is_wr;
        word  = gi ? ((ia % 32'h4000) / 4) : ((da % 32'h4000) / 4);
        is_wr = !gi && wen;
        inst_req_valid  = iv;  inst_addr  = ia;
        data_req_valid  = dv;  data_addr  = da;
        data_wen        = wen; data_wdata = wd; data_wstrb = ws;
        inst_resp_ready = 1'b0; data_resp_ready = 1'b0;
        #1;
        chk("grant_inst", inst_req_ready, gi);
        chk("grant_data", data_req_ready, !gi);
        @(posedge clk); #2;
        chk("busy_ready", {inst_req_ready, data_req_ready}, 0);
        chk("early_resp", {inst_resp_valid, data_resp_valid}, 0);
        chk("mem_rden", mem_rden, !is_wr);
        chk("mem_wren", mem_wren, is_wr);
        chk("mem_raddr", 32'(mem_raddr), word);
        chk("mem_waddr", 32'(mem_waddr), word);
        if (is_wr) begin
            chk("mem_wdata", mem_wdata, wd);
            chk("mem_wstrb", 32'(mem_wstrb), 32'(ws));
        end
        @(posedge clk); #1;
        for (int s = 0; s <= stall; s++) begin
            inst_resp_ready = (s == stall);
            data_resp_ready = (s == stall);
            #1;
            chk("resp_valid_i", inst_resp_valid, gi);
            chk("resp_valid_d", data_resp_valid, !gi);
            chk("rdata_i", inst_rdata, gi ? rd : 32'h0);
            chk("rdata_d", data_rdata, gi ? 32'h0 : rd);
            chk("resp_quiet", {inst_req_ready, data_req_ready, mem_wren, mem_rden}, 0);
            @(posedge clk); #1;
        end
        inst_req_valid  = 1'b0; data_req_valid  = 1'b0;
        inst_resp_ready = 1'b0; data_resp_ready = 1'b0;
    endtask

    typedef struct {
        bit          iv, dv, wen;
        logic [31:0] ia, da, wd;
        logic [3:0]  ws;
        int          stall;
        bit          gi;
        logic [31:0] rd;
    } vec_t;

    initial begin
        vec_t        tbl [8];
        bit          gi;
        logic [31:0] rd, ia, da, wd;
        logic [3:0]  ws;
        bit          iv, dv, wen;
        int          r;

        for (int i = 0; i < WORDS; i++) ref_mem[i] = init_word(i);
        m_last_data = 1'b1;

        tbl[0] = '{1'b1, 1'b0, 1'b0, 32'h10, 32'h0, 32'h0, 4'h0, 0, 1'b1, 32'hDEAD_BEEF};
        tbl[1] = '{1'b0, 1'b1, 1'b1, 32'h0, 32'h20, 32'h1122_3344, 4'b0101, 0, 1'b0, 32'h0};
        tbl[2] = '{1'b0, 1'b1, 1'b0, 32'h0, 32'h20, 32'h0, 4'h0, 10, 1'b0, 32'hFF22_FF44};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0, 4'h0, 0, 1'b1, 32'hDEAD_BEEF};
        tbl[4] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'hFF22_FF44};
        tbl[5] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0, 4'h0, 0, 1'b1, 32'hDEAD_BEEF};
        tbl[6] = '{1'b1, 1'b1, 1'b0, 32'h10, 32'h20, 32'h0, 4'h0, 0, 1'b0, 32'hFF22_FF44};
        tbl[7] = '{1'b1, 1'b0, 1'b0, 32'hFFFF_C013, 32'h0, 32'h0, 4'h0, 1, 1'b1, 32'hDEAD_BEEF};

        rst_n = 1'b0;
        inst_req_valid = 1'b1; data_req_valid = 1'b1;
        inst_addr = '0; data_addr = '0; data_wen = 1'b0; data_wdata = '0; data_wstrb = '0;
        inst_resp_ready = 1'b0; data_resp_ready = 1'b0;
        repeat (3) begin
            @(posedge clk); #2;
            chk("reset_outputs", {inst_req_ready, data_req_ready, inst_resp_valid,
                                  data_resp_valid, mem_wren, mem_rden}, 0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        inst_req_valid = 1'b0; data_req_valid = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            model_step(tbl[i].iv, tbl[i].dv, tbl[i].wen, tbl[i].ia, tbl[i].da,
                       tbl[i].wd, tbl[i].ws, gi, rd);
            run_txn(tbl[i].iv, tbl[i].dv, tbl[i].wen, tbl[i].ia, tbl[i].da,
                    tbl[i].wd, tbl[i].ws, tbl[i].stall, tbl[i].gi, tbl[i].rd);
        end

        for (int n = 0; n < 40; n++) begin
            r   = $urandom_range(1, 3);
            iv  = r[0];
            dv  = r[1];
            wen = $urandom_range(0, 1) == 1;
            ia  = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 11)) << 2);
            da  = ($urandom & 32'hFFFF_C003) | (32'($urandom_range(0, 11)) << 2);
            wd  = $urandom;
            ws  = 4'($urandom_range(0, 15));
            model_step(iv, dv, wen, ia, da, wd, ws, gi, rd);
            run_txn(iv, dv, wen, ia, da, wd, ws, $urandom_range(0, 3), gi, rd);
        end

        // Reset while a write to word 12 is in its access cycle.
        data_req_valid = 1'b1; data_wen = 1'b1; data_addr = 32'h30;
        data_wdata = 32'h0; data_wstrb = 4'hF;
        #1;
        chk("abort_grant", data_req_ready, 1);
        @(posedge clk); #1;
        rst_n = 1'b0;
        data_req_valid = 1'b0;
        #1;
        chk("abort_wren", mem_wren, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        data_wen = 1'b0;
        m_last_data = 1'b1;
        chk("abort_no_resp", {inst_resp_valid, data_resp_valid}, 0);
        ia = 32'h30;
        model_step(1'b1, 1'b0, 1'b0, ia, 32'h0, 32'h0, 4'h0, gi, rd);
        run_txn(1'b1, 1'b0, 1'b0, ia, 32'h0, 32'h0, 4'h0, 0, 1'b1, 32'hA5A5_A5A5);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
